// File: rtl/button_event_pkg.sv
// Shared types and sizing helpers for the button_event controller.
// The state enum and the counter-width function live here so the bench and RTL agree on them.
package button_event_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HELD  = 3'd1,
        ST_LONG  = 3'd2,
        ST_WAIT2 = 3'd3,
        ST_HELD2 = 3'd4
    } state_t;

    // One spare bit above the largest threshold keeps the saturating counter clear of wrap.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/button_event_edge.sv
// edge_detect: registers the button level and derives combinational rise/fall strobes.
// A rise is only reported once the level has been seen low after reset.
module edge_detect (
    input  logic clock,
    input  logic reset,
    input  logic in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic armed;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            level <= 1'b0;
            armed <= 1'b0;
        end else begin
            level <= in;
            armed <= armed | ~in;
        end
    end

    // A button already held at reset release must not look like a fresh press.
    assign rise = armed & in & ~level;
    assign fall = ~in & level;

endmodule

// File: rtl/button_event.sv
// button_event: press/release/click/long-press event generator for a debounced button.
// Define BUTTON_EVENT_REPEAT_EN to enable the auto-repeat pulse during a long hold.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | button released, no click pending
// HELD     | first press in progress, timing towards long press
// LONG     | long press reached, waiting for release (auto-repeat if enabled)
// WAIT2    | short press released, window open for a second press
// HELD2    | second press of a double click, waiting for release
module button_event
    import button_event_pkg::*;
#(
    parameter int LONG_CYCLES   = 50_000_000,
    parameter int DCLICK_CYCLES = 25_000_000,
    parameter int REPEAT_CYCLES = 10_000_000
) (
    input  logic clock,
    input  logic reset,
    input  logic in,
    output logic press,
    output logic release_p,
    output logic single_click,
    output logic double_click,
    output logic long_press,
    output logic repeat_p,
    output logic held
);

    localparam int CW = cnt_width(LONG_CYCLES, DCLICK_CYCLES, REPEAT_CYCLES);
    localparam logic [CW-1:0] LONG_TC   = CW'(LONG_CYCLES - 1);
    localparam logic [CW-1:0] DCLICK_TC = CW'(DCLICK_CYCLES - 1);
    localparam logic [CW-1:0] CNT_MAX   = '1;

    generate
        if (LONG_CYCLES < 2 || DCLICK_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_bad_param
            $error("button_event: cycle parameters must all be >= 2");
        end
    endgenerate

    logic          level;
    logic          rise;
    logic          fall;
    state_t        state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_inc;

    edge_detect u_edge (
        .clock (clock),
        .reset (reset),
        .in    (in),
        .level (level),
        .rise  (rise),
        .fall  (fall)
    );

    assign held    = level;
    assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;

`ifdef BUTTON_EVENT_REPEAT_EN
    localparam logic [CW-1:0] REPEAT_TC = CW'(REPEAT_CYCLES - 1);
    logic repeat_q;
    assign repeat_p = repeat_q;
`else
    assign repeat_p = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            press        <= 1'b0;
            release_p    <= 1'b0;
            single_click <= 1'b0;
            double_click <= 1'b0;
            long_press   <= 1'b0;
`ifdef BUTTON_EVENT_REPEAT_EN
            repeat_q     <= 1'b0;
`endif
        end else begin
            press        <= rise;
            release_p    <= fall;
            single_click <= 1'b0;
            double_click <= 1'b0;
            long_press   <= 1'b0;
`ifdef BUTTON_EVENT_REPEAT_EN
            repeat_q     <= 1'b0;
`endif
            case (state)
                ST_IDLE: begin
                    if (rise) begin
                        state <= ST_HELD;
                        cnt   <= '0;
                    end
                end
                // Release on the threshold cycle takes priority over the long press.
                ST_HELD: begin
                    if (fall) begin
                        state <= ST_WAIT2;
                        cnt   <= '0;
                    end else if (cnt == LONG_TC) begin
                        long_press <= 1'b1;
                        state      <= ST_LONG;
                        cnt        <= '0;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                ST_LONG: begin
                    if (fall) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
`ifdef BUTTON_EVENT_REPEAT_EN
                    end else if (cnt == REPEAT_TC) begin
                        repeat_q <= 1'b1;
                        cnt      <= '0;
                    end else begin
                        cnt <= cnt_inc;
`endif
                    end
                end
                // A second press on the timeout cycle still counts as a double click.
                ST_WAIT2: begin
                    if (rise) begin
                        double_click <= 1'b1;
                        state        <= ST_HELD2;
                        cnt          <= '0;
                    end else if (cnt == DCLICK_TC) begin
                        single_click <= 1'b1;
                        state        <= ST_IDLE;
                        cnt          <= '0;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                ST_HELD2: begin
                    if (fall) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_button_event.sv
// Directed bench for button_event with LONG=8, DCLICK=5, REPEAT=3.
// Output vector order: {press, release, single, double, long, repeat, held}.
module tb_button_event;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic in    = 1'b0;
    logic press, release_p, single_click, double_click, long_press, repeat_p, held;
    logic [6:0] outs;

    int n_chk  = 0;
    int n_fail = 0;

    localparam logic [6:0] P  = 7'b1000000;
    localparam logic [6:0] R  = 7'b0100000;
    localparam logic [6:0] S  = 7'b0010000;
    localparam logic [6:0] D  = 7'b0001000;
    localparam logic [6:0] L  = 7'b0000100;
    localparam logic [6:0] RP = 7'b0000010;
    localparam logic [6:0] H  = 7'b0000001;
`ifdef BUTTON_EVENT_REPEAT_EN
    localparam bit REP_ON = 1'b1;
`else
    localparam bit REP_ON = 1'b0;
`endif

    button_event #(
        .LONG_CYCLES   (8),
        .DCLICK_CYCLES (5),
        .REPEAT_CYCLES (3)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .in           (in),
        .press        (press),
        .release_p    (release_p),
        .single_click (single_click),
        .double_click (double_click),
        .long_press   (long_press),
        .repeat_p     (repeat_p),
        .held         (held)
    );

    always #5 clock = ~clock;

    assign outs = {press, release_p, single_click, double_click, long_press, repeat_p, held};

    task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic v, input logic [6:0] exp, input string tag);
        in = v;
        @(posedge clock);
        #1;
        check(tag, outs, exp);
    endtask

    initial begin
        // Reset state, asynchronously applied before any clock edge
        #2;
        check("reset_initial", outs, 7'b0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        cyc(0, 7'b0, "idle0");
        cyc(0, 7'b0, "idle1");

        // Single click: high 3, low, single 5 cycles after release
        cyc(1, P | H, "sc_press");
        cyc(1, H, "sc_hold1");
        cyc(1, H, "sc_hold2");
        cyc(0, R, "sc_release");
        for (int i = 1; i <= 4; i++) cyc(0, 7'b0, $sformatf("sc_wait%0d", i));
        cyc(0, S, "sc_single");
        cyc(0, 7'b0, "sc_after");

        // Double click: high 2, low 2, high 2
        cyc(1, P | H, "dc_press1");
        cyc(1, H, "dc_hold1");
        cyc(0, R, "dc_rel1");
        cyc(0, 7'b0, "dc_gap");
        cyc(1, P | D | H, "dc_press2");
        cyc(1, H, "dc_hold2");
        cyc(0, R, "dc_rel2");
        for (int i = 1; i <= 6; i++) cyc(0, 7'b0, $sformatf("dc_nosingle%0d", i));

        // Long press held 20 cycles, repeat every 3 after long when enabled
        cyc(1, P | H, "lp_press");
        for (int j = 1; j <= 19; j++) begin
            logic [6:0] e;
            e = H;
            if (j == 8) e = e | L;
            if (REP_ON && j > 8 && ((j - 8) % 3) == 0) e = e | RP;
            cyc(1, e, $sformatf("lp_hold%0d", j));
        end
        cyc(0, R, "lp_release");
        for (int i = 1; i <= 7; i++) cyc(0, 7'b0, $sformatf("lp_noclick%0d", i));

        // Release exactly on the long threshold: no long, single click follows
        cyc(1, P | H, "th_press");
        for (int j = 1; j <= 7; j++) cyc(1, H, $sformatf("th_hold%0d", j));
        cyc(0, R, "th_release");
        for (int i = 1; i <= 4; i++) cyc(0, 7'b0, $sformatf("th_wait%0d", i));
        cyc(0, S, "th_single");
        cyc(0, 7'b0, "th_after");

        // Second press exactly on the WAIT2 timeout: double only
        cyc(1, P | H, "to_press1");
        cyc(1, H, "to_hold1");
        cyc(0, R, "to_rel1");
        for (int i = 1; i <= 4; i++) cyc(0, 7'b0, $sformatf("to_wait%0d", i));
        cyc(1, P | D | H, "to_press2");
        cyc(1, H, "to_hold2");
        cyc(0, R, "to_rel2");
        for (int i = 1; i <= 6; i++) cyc(0, 7'b0, $sformatf("to_nosingle%0d", i));

        // Reset asserted mid-hold with in=1
        cyc(1, P | H, "rs_press");
        cyc(1, H, "rs_hold1");
        cyc(1, H, "rs_hold2");
        reset = 1'b0;
        #2;
        check("rs_async_clear", outs, 7'b0);
        cyc(1, 7'b0, "rs_in_reset");
        #2;
        reset = 1'b1;
        cyc(1, H, "rs_nopress1");
        cyc(1, H, "rs_nopress2");
        cyc(1, H, "rs_nopress3");
        cyc(0, R, "rs_low");
        cyc(0, 7'b0, "rs_low2");
        cyc(1, P | H, "rs_repress");
        cyc(0, R, "rs_rerelease");
        for (int i = 1; i <= 4; i++) cyc(0, 7'b0, $sformatf("rs_wait%0d", i));
        cyc(0, S, "rs_single");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
